// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, status field positions, reset values and fixed IDs.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_LO   = 10;
    localparam int IM_HI   = 15;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL_DEF     = 32'h4D49_5053;

    localparam logic [5:0]  IP_RST  = 6'd0;
    localparam logic [5:0]  IM_RST  = 6'd0;
    localparam logic        EXL_RST = 1'b0;
    localparam logic        IE_RST  = 1'b0;
    localparam logic [31:0] EPC_RST = 32'd0;

    // Reassembles the architectural SR word; bits outside IM/EXL/IE read as zero.
    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] w;
        w                = 32'd0;
        w[IM_HI:IM_LO]   = im;
        w[EXL_BIT]       = exl;
        w[IE_BIT]        = ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_ip_unit.sv
// Cause.IP register: samples HWINT every edge, or accumulates it with W1C clear when CP0_INT_LATCH_EN is defined.
// Latency: one edge from HWINT to IP. No backpressure; the clear strobe is a plain write enable.
module cp0_ip_unit
    import cp0_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hwint,
    input  logic       clr_vld,
    input  logic [5:0] clr_dat,
    output logic [5:0] ip
);

    logic [5:0] ip_q;
    logic [5:0] ip_d;

`ifdef CP0_INT_LATCH_EN
    // OR-ing hwint after the clear keeps a bit set when it is raised and cleared on the same edge.
    always_comb begin
        ip_d = (ip_q & ~(clr_vld ? clr_dat : 6'd0)) | hwint;
    end
`else
    logic unused_clr;
    assign unused_clr = clr_vld ^ (^clr_dat);

    always_comb begin
        ip_d = hwint;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_q <= IP_RST;
        end else begin
            ip_q <= ip_d;
        end
    end

    assign ip = ip_q;

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId, exception-entry request, eret handling (IP behaviour set by CP0_INT_LATCH_EN).
// Latency: register updates one edge; IntReq and DOUT combinational from registered state. No backpressure.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter logic [31:0] PRID_VAL     = PRID_VAL_DEF
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [5:0]  HWINT,
    input  logic [29:0] PC,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIN,
    input  logic        WE,
    input  logic        ERET,
    output logic [31:0] DOUT,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] VEC,
    output logic        exlclr
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [31:0] epc_q, epc_d;
    logic        exlclr_q, exlclr_d;
    logic [5:0]  ip;
    logic        wr_sr, wr_epc, wr_cause, eret_ok;

    logic unused_din;
    assign unused_din = ^{DIN[31:16], DIN[9:2]};

    assign wr_sr    = WE && (A2 == REG_SR);
    assign wr_epc   = WE && (A2 == REG_EPC);
    assign wr_cause = WE && (A2 == REG_CAUSE);
    assign eret_ok  = ERET && exl_q;

    cp0_ip_unit u_ip (
        .clk     (CLK_I),
        .rst     (RST_I),
        .hwint   (HWINT),
        .clr_vld (wr_cause),
        .clr_dat (DIN[IM_HI:IM_LO]),
        .ip      (ip)
    );

    assign IntReq = (|(ip & im_q)) && ie_q && !exl_q;

    // Priority order: mtc0, then eret clears EXL, then entry forces EXL and EPC.
    always_comb begin
        im_d     = im_q;
        exl_d    = exl_q;
        ie_d     = ie_q;
        epc_d    = epc_q;
        exlclr_d = 1'b0;
        if (wr_sr) begin
            im_d  = DIN[IM_HI:IM_LO];
            exl_d = DIN[EXL_BIT];
            ie_d  = DIN[IE_BIT];
        end
        if (wr_epc) begin
            epc_d = DIN;
        end
        if (eret_ok) begin
            exl_d    = 1'b0;
            exlclr_d = 1'b1;
        end
        if (IntReq) begin
            exl_d = 1'b1;
            epc_d = {PC, 2'b00};
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            im_q     <= IM_RST;
            exl_q    <= EXL_RST;
            ie_q     <= IE_RST;
            epc_q    <= EPC_RST;
            exlclr_q <= 1'b0;
        end else begin
            im_q     <= im_d;
            exl_q    <= exl_d;
            ie_q     <= ie_d;
            epc_q    <= epc_d;
            exlclr_q <= exlclr_d;
        end
    end

    always_comb begin
        case (A1)
            REG_SR:    DOUT = sr_word(im_q, exl_q, ie_q);
            REG_CAUSE: DOUT = {16'd0, ip, 10'd0};
            REG_EPC:   DOUT = epc_q;
            REG_PRID:  DOUT = PRID_VAL;
            default:   DOUT = 32'd0;
        endcase
    end

    assign EPC    = epc_q;
    assign VEC    = HANDLER_ADDR;
    assign exlclr = exlclr_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Bench for cp0_intc: word-level register model checked every cycle, plus directed literal scenarios and random traffic.
module tb_cp0_intc;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [5:0]  HWINT = '0;
    logic [29:0] PC    = '0;
    logic [4:0]  A1    = '0;
    logic [4:0]  A2    = '0;
    logic [31:0] DIN   = '0;
    logic        WE    = 1'b0;
    logic        ERET  = 1'b0;
    logic [31:0] DOUT;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] VEC;
    logic        exlclr;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    cp0_intc dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .HWINT  (HWINT),
        .PC     (PC),
        .A1     (A1),
        .A2     (A2),
        .DIN    (DIN),
        .WE     (WE),
        .ERET   (ERET),
        .DOUT   (DOUT),
        .IntReq (IntReq),
        .EPC    (EPC),
        .VEC    (VEC),
        .exlclr (exlclr)
    );

    always #5 CLK_I = ~CLK_I;

    // Model keeps SR and Cause as whole architectural words.
    logic [31:0] m_sr = '0;
    logic [31:0] m_cause = '0;
    logic [31:0] m_epc = '0;
    logic        m_exlclr = 1'b0;
    logic [31:0] n_sr, n_cause, n_epc;
    logic        take, ret;

    function automatic logic m_intreq();
        return ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h4D49_5053;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            m_sr = '0; m_cause = '0; m_epc = '0; m_exlclr = 1'b0;
        end else begin
            take  = m_intreq();
            ret   = ERET && m_sr[1];
            n_sr  = m_sr;
            n_epc = m_epc;
            if (WE && A2 == 5'd12) n_sr = DIN & 32'h0000_FC03;
            if (WE && A2 == 5'd14) n_epc = DIN;
            if (ret) n_sr[1] = 1'b0;
            if (take) begin
                n_sr[1] = 1'b1;
                n_epc   = {PC, 2'b00};
            end
`ifdef CP0_INT_LATCH_EN
            n_cause = m_cause;
            if (WE && A2 == 5'd13) n_cause = n_cause & ~(DIN & 32'h0000_FC00);
            n_cause = n_cause | {16'd0, HWINT, 10'd0};
`else
            n_cause = {16'd0, HWINT, 10'd0};
`endif
            m_sr = n_sr; m_cause = n_cause; m_epc = n_epc; m_exlclr = ret;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK_I) begin
        if (started) begin
            chk("m_intreq", {31'd0, IntReq}, {31'd0, m_intreq()});
            chk("m_epc",    EPC,             m_epc);
            chk("m_exlclr", {31'd0, exlclr}, {31'd0, m_exlclr});
            chk("m_dout",   DOUT,            m_read(A1));
            chk("m_vec",    VEC,             32'h0000_4180);
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; A2 = a; DIN = d;
    endtask

    initial begin
        step(); step();
        RST_I = 1'b0;
        started = 1'b1;
        A1 = 5'd15;
        #1;
        chk("rst_intreq", {31'd0, IntReq}, 32'd0);
        chk("rst_prid", DOUT, 32'h4D49_5053);

        // Timer interrupt and entry.
        mtc0(5'd12, 32'h0000_0401); step();
        WE = 1'b0; PC = 30'h0000_0C05; HWINT = 6'b000001; step();
        A1 = 5'd13; #1;
        chk("timer_intreq_hi", {31'd0, IntReq}, 32'd1);
        chk("timer_ip", DOUT, 32'h0000_0400);
        HWINT = 6'd0; mtc0(5'd13, 32'h0000_FC00); step();
        WE = 1'b0; A1 = 5'd12; #1;
        chk("timer_intreq_lo", {31'd0, IntReq}, 32'd0);
        chk("timer_epc", EPC, 32'h0000_3014);
        chk("timer_sr_exl", DOUT, 32'h0000_0403);
        step();
        chk("timer_intreq_stays_lo", {31'd0, IntReq}, 32'd0);

        // eret with and without EXL.
        ERET = 1'b1; step();
        chk("eret_pulse", {31'd0, exlclr}, 32'd1);
        chk("eret_sr", DOUT, 32'h0000_0401);
        ERET = 1'b0; step();
        chk("eret_pulse_end", {31'd0, exlclr}, 32'd0);
        ERET = 1'b1; step();
        chk("eret_ignored", {31'd0, exlclr}, 32'd0);
        ERET = 1'b0;

        // Masking: IM=0, then IE=0.
        mtc0(5'd12, 32'h0000_0001); HWINT = 6'b111111; step();
        WE = 1'b0; A1 = 5'd13; step();
        chk("mask_im_intreq", {31'd0, IntReq}, 32'd0);
        chk("mask_ip", DOUT, 32'h0000_FC00);
        mtc0(5'd12, 32'h0000_FC00); step();
        WE = 1'b0; step();
        chk("mask_ie_intreq", {31'd0, IntReq}, 32'd0);
        chk("mask_ip2", DOUT, 32'h0000_FC00);
        HWINT = 6'd0; mtc0(5'd13, 32'h0000_FC00); step();
        WE = 1'b0;

        // Entry collides with mtc0 EPC.
        mtc0(5'd12, 32'h0000_0401); step();
        WE = 1'b0; PC = 30'h0000_1111; HWINT = 6'b000001; step();
        HWINT = 6'd0; mtc0(5'd14, 32'hDEAD_BEEF); step();
        chk("coll_epc", EPC, 32'h0000_4444);
        mtc0(5'd13, 32'h0000_FC00); ERET = 1'b1; step();
        WE = 1'b0; ERET = 1'b0;

        // Entry collides with mtc0 SR.
        HWINT = 6'b000001; step();
        HWINT = 6'd0; mtc0(5'd12, 32'h0000_0400); A1 = 5'd12; step();
        chk("coll_sr", DOUT, 32'h0000_0402);
        mtc0(5'd13, 32'h0000_FC00); ERET = 1'b1; step();
        WE = 1'b0; ERET = 1'b0;

        // IP behaviour after a one-cycle pulse.
        mtc0(5'd12, 32'h0000_0000); step();
        WE = 1'b0; A1 = 5'd13; HWINT = 6'b000100; step();
        HWINT = 6'd0; step();
`ifdef CP0_INT_LATCH_EN
        chk("latch_sticky", DOUT, 32'h0000_1000);
        mtc0(5'd13, 32'h0000_1000); step();
        WE = 1'b0;
        chk("latch_cleared", DOUT, 32'h0000_0000);
`else
        chk("ip_follows", DOUT, 32'h0000_0000);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            HWINT = 6'($urandom) & 6'($urandom) & 6'($urandom);
            PC    = 30'($urandom);
            A1    = 5'($urandom_range(8, 20));
            A2    = 5'($urandom_range(10, 17));
            DIN   = $urandom;
            WE    = ($urandom_range(0, 7) == 0);
            ERET  = ($urandom_range(0, 5) == 0);
            step();
        end
        WE = 1'b0; ERET = 1'b0; HWINT = 6'd0;

        // Reset asserted between edges with live state.
        mtc0(5'd14, 32'h0000_1234); step();
        mtc0(5'd12, 32'h0000_0403); step();
        WE = 1'b0;
        #2;
        RST_I = 1'b1;
        A1 = 5'd15;
        #1;
        chk("midrst_intreq", {31'd0, IntReq}, 32'd0);
        chk("midrst_epc", EPC, 32'd0);
        chk("midrst_exlclr", {31'd0, exlclr}, 32'd0);
        chk("midrst_prid", DOUT, 32'h4D49_5053);
        chk("midrst_vec", VEC, 32'h0000_4180);
        A1 = 5'd12;
        #1;
        chk("midrst_sr", DOUT, 32'd0);
        step();
        RST_I = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Coprocessor-0 interrupt controller for the MIPS core: the consuming end of the peripheral `IRQ` lines, with the timer at `HWINT[0]`. It samples device interrupt requests into Cause.IP and masks them with SR. It requests exception entry from the pipeline, saves the victim PC into EPC, and on `eret` releases EXL and pulses `exlclr` back to the peripherals. It sits beside the datapath and serves `mfc0`/`mtc0` through a small register port.

## Interface
- `HANDLER_ADDR`, 32'h0000_4180, exception vector driven on `VEC`.
- `PRID_VAL`, 32'h4D49_5053, constant value of PRId.
- `CLK_I` in 1: clock; all state updates on the rising edge.
- `RST_I` in 1: asynchronous, active-high reset.
- `HWINT` in 6: device interrupt requests, level, `[0]` = timer `IRQ`.
- `PC` in 30: word address of the instruction to be victimised (PC[31:2]).
- `A1` in 5: `mfc0` read select.
- `A2` in 5: `mtc0` write select.
- `DIN` in 32: `mtc0` write data.
- `WE` in 1: `mtc0` write strobe.
- `ERET` in 1: `eret` committing this cycle.
- `DOUT` out 32: read data for `A1`, combinational.
- `IntReq` out 1: exception-entry request to the pipeline.
- `EPC` out 32: saved return address.
- `VEC` out 32: constant `HANDLER_ADDR`.
- `exlclr` out 1: one-cycle pulse after an accepted `eret`, wired to the timer.

## Operation
- Register map (index: fields):
  - 12 SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - 13 Cause: IP[15:10], ExcCode[6:2] always 0; all other bits read 0.
  - 14 EPC: full 32 bits.
  - 15 PRId: `PRID_VAL`, read-only.
  - Any other index reads 0, and writes to it are ignored.
- Reset values: SR=0, Cause=0, EPC=0, `exlclr`=0. Consequently `IntReq`=0, and `DOUT` reflects the zeroed registers.
- `IntReq` = |(IP & IM) & IE & ~EXL. It is combinational from registered state.
- Entry: at any edge where `IntReq`=1:
  - EXL<=1.
  - EPC<={PC,2'b00}.
  - `IntReq` falls in the following cycle.
- `eret`: at an edge with `ERET`=1 and EXL=1:
  - EXL<=0.
  - `exlclr`<=1 for exactly one cycle.
  - `ERET` while EXL=0 is ignored and produces no pulse.
- `mtc0`: with `WE`=1, SR takes IM/EXL/IE from `DIN`, and EPC takes `DIN`. Cause and PRId are read-only, except as described under Configuration.
- Simultaneous events:
  - Entry and `mtc0` SR in the same edge: IM and IE take `DIN`, and EXL is forced to 1.
  - Entry and `mtc0` EPC in the same edge: the entry value wins.
  - Entry and `ERET` cannot coincide, because EXL gates `IntReq`.
  - `ERET` and `mtc0` SR in the same edge: EXL=0 and IM/IE take `DIN`.
- Reset asserted mid-handler returns all state to reset values immediately, regardless of the clock.

## Timing
- `HWINT` rises before edge n: IP is set at edge n, `IntReq` is high during cycle n (if unmasked), and EXL and EPC update at edge n+1.
- `ERET` sampled at edge m: `exlclr` is high from m to m+1, and the timer restarts counting at edge m+1.
- Read path: `DOUT` is valid in the same cycle as `A1`, and a write at edge k is visible to reads after k.
- No handshakes; single-cycle latency on every register update.

## Configuration
- `CP0_INT_LATCH_EN` undefined: IP<=`HWINT` every edge. A pending request vanishes when the device deasserts.
- `CP0_INT_LATCH_EN` defined:
  - IP<=IP|`HWINT`, so it is sticky.
  - `mtc0` to Cause with `DIN[15:10]` clears the corresponding IP bits (write-1-to-clear).
  - A bit that is both set by `HWINT` and cleared in the same edge stays set.

## Structure
- `cp0_pkg` holds:
  - register indices (SR=12, CAUSE=13, EPC=14, PRID=15);
  - field bit positions (IM_LO=10, IM_HI=15, EXL=1, IE=0);
  - reset values.
- One sub-module, `cp0_ip_unit`, holds the IP register and its sampling/latching/clear logic, including the `CP0_INT_LATCH_EN` variant. Everything else lives in `cp0_intc`.

## Test plan
- Reset check: assert `RST_I` mid-clock. All outputs must be 0 immediately, `DOUT`@A1=15 must read 32'h4D49_5053, and `VEC` must be 32'h0000_4180.
- Timer interrupt and entry:
  - Stimulus: `mtc0` SR=32'h0000_0401, `PC`=30'h0000_0C05, then pulse `HWINT[0]`.
  - Required: `IntReq` high for exactly one cycle, then EXL=1 and EPC=32'h0000_3014.
- Masking: set IM=0 or IE=0 and raise `HWINT`=6'b111111. `IntReq` must stay 0 while IP reads 6'b111111.
- `eret`:
  - Stimulus: with EXL=1, pulse `ERET`.
  - Required: EXL=0 and `exlclr` high for exactly one cycle.
  - Second check: pulse `ERET` again with EXL=0; `exlclr` must stay 0.
- Collision:
  - Stimulus: entry edge coincides with `mtc0` EPC=32'hDEAD_BEEF.
  - Required: EPC={`PC`,2'b00}.
  - Second check: entry coincides with `mtc0` SR=32'h0000_0400; the result must be SR=32'h0000_0402.
- `CP0_INT_LATCH_EN` build:
  - Stimulus: pulse `HWINT[2]` for one cycle, then drop it.
  - Required: IP[12] stays 1; `mtc0` Cause with DIN=32'h0000_1000 clears it.
